decodificador_fifo: RTL
=======================

// Module: decodificador_fifo
// PURPOSE
//  Downstream of the 4-bit encoder stage. Samples its coded word S0..S3 on each Ready rising edge.
//  Decodes the word back to the data nibble ABCD and buffers it in a DEPTH-entry FWFT FIFO.
//  Presents words to the consumer (display/checker) through a valid/ack handshake.
// PARAMETERS
//  DEPTH  4  FIFO entries; power of two, >=2. CW = $clog2(DEPTH)+1 (Count width)
// PORTS
//  Clock       in   1   single clock, rising edge
//  Reset_n     in   1   asynchronous, active-low reset
//  S0,S1,S2,S3 in   1   coded word from encoder stage (S0 = MSB of code)
//  Ready       in   1   level from encoder stage; rising edge = new word
//  Clear       in   1   synchronous flush
//  Dout        out  4   decoded nibble {A,B,C,D} at FIFO head; 0000 when Empty
//  Dout_valid  out  1   head word present (= ~Empty)
//  Dout_ack    in   1   consumer accepts head when Dout_valid & Dout_ack
//  Count       out  CW  words stored, 0..DEPTH
//  Full, Empty out  1   FIFO status
//  Overflow    out  1   sticky: a word was dropped because FIFO was full
// BEHAVIOUR
//  Reset (Reset_n=0, immediate): Dout=0000, Dout_valid=0, Count=0, Full=0, Empty=1, Overflow=0.
//  Reset also sets internal Ready_q=1.
//  Edge detect: Ready_q <= Ready every cycle; push = Ready & ~Ready_q.
//  - Ready held high through reset release: no capture until Ready is seen low, then high.
//  Decode (pure lookup at push; code S0S1S2S3 -> ABCD hex):
//    0101->0 1100->1 1001->2 0000->3 0001->4 1111->5 0100->6 1011->7
//    0111->8 0011->9 1101->A 0010->B 1110->C 1000->D 0110->E 1010->F
//  - Bijective: every code is valid. The encoder's forced-reset pattern 1111 decodes as 5.
//  - 1111 is captured only on a Ready edge.
//  FIFO stores decoded nibbles. Pop = Dout_valid & Dout_ack.
//  Latency: push at edge t -> Dout/Dout_valid valid after edge t (empty FIFO).
//  Ordering strictly FIFO. Ptrs wrap modulo DEPTH.
//  Priority per cycle: Clear > push/pop.
//  - Clear=1: Count=0, Empty=1, Overflow=0, pointers to 0; coincident push and pop discarded.
//    Ready_q still updates.
//  - push & ~Full: write at tail, Count+1 (unless popping too).
//  - push & Full & pop: accepted; Count stays DEPTH; Overflow unchanged.
//  - push & Full & ~pop: word dropped, Overflow<=1, FIFO unchanged.
//  - pop when Empty: impossible (Dout_valid=0); Dout_ack ignored.
//  - push & pop on Empty: push only; word visible next cycle.
//  Full = (Count==DEPTH), Empty = (Count==0); both registered-consistent with Count.
// CONFIGURATION
//  DECOD_SYNC_EN defined: S0..S3 and Ready pass through a 2-flop synchronizer (reset to 0).
//  - Ready sync stage resets to 1.
//  - Edge detect and decode use synchronized values; capture latency +2 cycles.
//  DECOD_SYNC_EN undefined: inputs used directly; upstream guarantees setup/hold to Clock.
// TESTING
//  1. Reset; S=0101, Ready 0->1 -> next cycle Dout=0000, Dout_valid=1, Count=1.
//     With DECOD_SYNC_EN: 2 cycles later.
//  2. 16 edges, codes in table order, Dout_ack=1 -> Dout sequence 0..F.
//     Overflow=0, Empty=1 at end.
//  3. DEPTH=4, 5 edges (codes 0101,1100,1001,0000,0001), ack=0.
//     -> Full=1 after 4th, Overflow=1 after 5th, Dout=0000.
//     Drain yields 0,1,2,3.
//  4. Full FIFO, edge (code 1010) with Dout_ack=1 same cycle -> Count=4, Overflow=0.
//     Drain tail word = F.
//  5. 2 words stored + Overflow=1; Clear=1 coincident with edge -> Count=0, Empty=1.
//     Overflow=0; pushed word not stored.
//  6. Reset_n low mid-stream -> all outputs to reset values without clock.
//     Ready held high at release -> no push until Ready low->high.

Source files
------------

// File: rtl/decodificador_fifo.sv
// Decoder + FWFT FIFO: samples the 4-bit code S0..S3 on each Ready rising edge and decodes it to nibble ABCD.
// Latency: a word captured at edge t is visible at Dout after edge t (+2 cycles with DECOD_SYNC_EN).
// Backpressure: the head is held until Dout_valid & Dout_ack. A push into a full FIFO without a pop is dropped and sets Overflow.
//
// Ports: Clock, Reset_n (async active-low), S0..S3 (S0 = code MSB), Ready (rising edge = new word),
//        Clear (sync flush), Dout/Dout_valid/Dout_ack (FWFT head handshake), Count, Full, Empty, Overflow (sticky).
// Optional macro DECOD_SYNC_EN: runs S0..S3 and Ready through a 2-flop synchronizer before edge detect and decode.
module decodificador_fifo #(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          Clock,
   input  logic          Reset_n,
   input  logic          S0,
   input  logic          S1,
   input  logic          S2,
   input  logic          S3,
   input  logic          Ready,
   input  logic          Clear,
   output logic [3:0]    Dout,
   output logic          Dout_valid,
   input  logic          Dout_ack,
   output logic [CW-1:0] Count,
   output logic          Full,
   output logic          Empty,
   output logic          Overflow
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [3:0]    code_in;
   logic          ready_in;
   logic          ready_q;
   logic          push;
   logic          pop;
   logic          wr_en;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          ovf;
   logic [3:0]    mem [DEPTH];

`ifdef DECOD_SYNC_EN
   logic [3:0] code_s1, code_s2;
   logic       ready_s1, ready_s2;

   // The Ready stages reset high so that a Ready held high across reset does not look like an edge.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         code_s1  <= 4'h0;
         code_s2  <= 4'h0;
         ready_s1 <= 1'b1;
         ready_s2 <= 1'b1;
      end else begin
         code_s1  <= {S0, S1, S2, S3};
         code_s2  <= code_s1;
         ready_s1 <= Ready;
         ready_s2 <= ready_s1;
      end
   end

   assign code_in  = code_s2;
   assign ready_in = ready_s2;
`else
   assign code_in  = {S0, S1, S2, S3};
   assign ready_in = Ready;
`endif

   // The code-to-nibble mapping is a bijection, so every code decodes.
   function automatic logic [3:0] decode(input logic [3:0] code);
      case (code)
         4'b0101: decode = 4'h0;
         4'b1100: decode = 4'h1;
         4'b1001: decode = 4'h2;
         4'b0000: decode = 4'h3;
         4'b0001: decode = 4'h4;
         4'b1111: decode = 4'h5;
         4'b0100: decode = 4'h6;
         4'b1011: decode = 4'h7;
         4'b0111: decode = 4'h8;
         4'b0011: decode = 4'h9;
         4'b1101: decode = 4'hA;
         4'b0010: decode = 4'hB;
         4'b1110: decode = 4'hC;
         4'b1000: decode = 4'hD;
         4'b0110: decode = 4'hE;
         default: decode = 4'hF;   // 1010
      endcase
   endfunction

   assign Empty      = (cnt == '0);
   assign Full       = (cnt == DEPTH_C);
   assign Count      = cnt;
   assign Overflow   = ovf;
   assign Dout_valid = ~Empty;
   assign Dout       = Empty ? 4'h0 : mem[rd_ptr];

   assign push  = ready_in & ~ready_q;
   assign pop   = ~Empty & Dout_ack;
   // When full, a simultaneous pop frees the slot at rd_ptr, which is the slot wr_ptr points to.
   assign wr_en = push & ~Clear & (~Full | pop);

   always_ff @(posedge Clock) begin
      if (wr_en) mem[wr_ptr] <= decode(code_in);
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         ready_q <= 1'b1;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt     <= '0;
         ovf     <= 1'b0;
      end else begin
         ready_q <= ready_in;   // edge detector tracks Ready even during Clear
         if (Clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
         end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)      cnt <= cnt + 1'b1;
            else if (!wr_en && pop) cnt <= cnt - 1'b1;
            if (push && Full && !pop) ovf <= 1'b1;
         end
      end
   end

endmodule
